// File: rtl/mealy_overlap_1101_pkg.sv
// Shared constants for the 1101 serial pattern detector.
package mealy_overlap_1101_pkg;

    localparam int DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

endpackage

// File: rtl/mealy_overlap_1101.sv
// Overlapping Mealy pattern detector; state is the matched prefix length.
module mealy_overlap_1101
    import mealy_overlap_1101_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int SW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam int NST  = 1 << SW;
    localparam int TBW  = 2 * NST * SW;

    // Entry (s,b): longest proper prefix that is a suffix of prefix_s + b.
    function automatic logic [TBW-1:0] build_tbl();
        logic [TBW-1:0] t;
        int best;
        int j;
        logic ok;
        logic sb;
        t = '0;
        for (int s = 0; s < NST; s++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                if (s < PAT_LEN) begin
                    for (int k = 1; k < PAT_LEN; k++) begin
                        if (k <= s + 1) begin
                            ok = 1'b1;
                            for (int i = 0; i < k; i++) begin
                                j = s + 1 - k + i;
                                if (j == s)
                                    sb = b[0];
                                else
                                    sb = PATTERN[PAT_LEN-1-j];
                                if (sb != PATTERN[PAT_LEN-1-i])
                                    ok = 1'b0;
                            end
                            if (ok)
                                best = k;
                        end
                    end
                end
                t[(s*2+b)*SW +: SW] = best[SW-1:0];
            end
        end
        return t;
    endfunction

    localparam logic [TBW-1:0] NS_TBL = build_tbl();

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic          w_out;
    int            w_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= SW'(S0);
        else
            r_state <= w_next;
    end

    always_comb begin
        w_idx  = 0;
        w_next = '0;
        w_out  = 1'b0;
        w_idx  = (int'(r_state) * 2 + int'(in)) * SW;
        w_next = NS_TBL[w_idx +: SW];
        w_out  = rst
              && (int'(r_state) == PAT_LEN - 1)
              && (in == PATTERN[0]);
    end

    assign out = w_out;

endmodule

// File: tb/tb_mealy_overlap_1101.sv
// Directed bench for mealy_overlap_1101 (default and 1010 patterns).
module tb_mealy_overlap_1101;

    logic clk;
    logic rst;
    logic in_a;
    logic in_b;
    logic out_a;
    logic out_b;

    int errors;
    int checks;

    mealy_overlap_1101 dut (
        .clk (clk),
        .rst (rst),
        .in  (in_a),
        .out (out_a)
    );

    mealy_overlap_1101 #(
        .PAT_LEN (4),
        .PATTERN (4'b1010)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .in  (in_b),
        .out (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit on the default instance and check out before the edge.
    task automatic step_a(input logic b, input logic exp, input string tag);
        @(negedge clk);
        in_a = b;
        #1;
        chk(tag, out_a, exp);
    endtask

    task automatic step_b(input logic b, input logic exp, input string tag);
        @(negedge clk);
        in_b = b;
        #1;
        chk(tag, out_b, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        in_a = 1'b0;
        in_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [13:0] ov_in;
    logic [13:0] ov_exp;
    logic [5:0]  r1_in;
    logic [5:0]  r1_exp;
    logic [7:0]  nm_in;
    logic [7:0]  nm_exp;
    logic [5:0]  pb_in;
    logic [5:0]  pb_exp;

    initial begin
        errors = 0;
        checks = 0;
        rst  = 1'b0;
        in_a = 1'b0;
        in_b = 1'b0;

        // Reset held with input toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_a = i[0];
            #1;
            chk("rst_out", out_a, 1'b0);
            chk("rst_state", (dut.r_state === 2'd0), 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        in_a = 1'b0;

        // Overlap stream, MSB = first bit.
        ov_in  = 14'b01011011011011;
        ov_exp = 14'b00000010010010;
        for (int i = 13; i >= 0; i--)
            step_a(ov_in[i], ov_exp[i], $sformatf("ovl_b%0d", 14 - i));

        do_reset();
        r1_in  = 6'b111101;
        r1_exp = 6'b000001;
        for (int i = 5; i >= 0; i--)
            step_a(r1_in[i], r1_exp[i], $sformatf("ones_b%0d", 6 - i));

        do_reset();
        nm_in  = 8'b11001101;
        nm_exp = 8'b00000001;
        for (int i = 7; i >= 0; i--)
            step_a(nm_in[i], nm_exp[i], $sformatf("near_b%0d", 8 - i));

        // Async reset while in S3 with the completing bit on the input.
        do_reset();
        step_a(1'b1, 1'b0, "mid_b1");
        step_a(1'b1, 1'b0, "mid_b2");
        step_a(1'b0, 1'b0, "mid_b3");
        @(negedge clk);
        in_a = 1'b1;
        #1;
        chk("pre_rst_match", out_a, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_state", (dut.r_state === 2'd0), 1'b1);
        chk("async_out", out_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step_a(1'b1, 1'b0, "post_rst_1");
        step_a(1'b1, 1'b0, "post_b1");
        step_a(1'b1, 1'b0, "post_b2");
        step_a(1'b0, 1'b0, "post_b3");
        step_a(1'b1, 1'b1, "post_b4");

        // Alternate pattern 1010.
        do_reset();
        pb_in  = 6'b101010;
        pb_exp = 6'b000101;
        for (int i = 5; i >= 0; i--)
            step_b(pb_in[i], pb_exp[i], $sformatf("p1010_b%0d", 6 - i));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
